// File: rtl/mux_pkg.sv
// Shared definitions for the channel multiplexer family: mode encodings and index wrap helper.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int wrap_inc(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Combinational round-robin priority picker: first requester at or after start, wrapping modulo N.
module rr_pick_n
    import mux_pkg::*;
#(
    parameter int N    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] start,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx,
    output logic            any
);

    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int off = 0; off < N; off++) begin
            k = (int'(start) + off) % N;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = SELW'(k);
            end
        end
    end

endmodule

// File: rtl/mux_sched_n1.sv
// Registered N-to-1 channel mux with manual or round-robin selection and a one-deep valid/ready output.
// Optional macro MUX_SEL_ERR_EN adds a sticky sel_err flag for out-of-range manual selects.
module mux_sched_n1
    import mux_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int W    = 1,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  i,
    input  logic [N-1:0]    i_valid,
    output logic [N-1:0]    i_ack,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    y,
    output logic [SELW-1:0] y_sel,
    output logic            y_valid,
    input  logic            y_ready
`ifdef MUX_SEL_ERR_EN
    ,
    output logic            sel_err
`endif
);

    logic [SELW-1:0] rr_ptr;
    logic [N-1:0]    rr_grant;
    logic [SELW-1:0] rr_idx;
    logic            rr_any;
    logic            load;
    logic            sel_ok;
    logic            capture;
    logic [SELW-1:0] cap_idx;
    logic [W-1:0]    cap_data;

    rr_pick_n #(.N(N), .SELW(SELW)) u_pick (
        .req   (i_valid),
        .start (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    assign load   = !y_valid || y_ready;
    assign sel_ok = ({1'b0, sel} < (SELW + 1)'(N));

    // Selection is only evaluated on load cycles, so a held word never changes.
    always_comb begin
        capture = 1'b0;
        cap_idx = '0;
        i_ack   = '0;
        if (!rst && load) begin
            if (mode == MODE_RR) begin
                capture = rr_any;
                cap_idx = rr_idx;
                if (rr_any) i_ack = rr_grant;
            end else if (sel_ok) begin
                capture = i_valid[sel];
                cap_idx = sel;
                if (i_valid[sel]) i_ack[sel] = 1'b1;
            end
        end
    end

    assign cap_data = i[int'(cap_idx)*W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_sel   <= '0;
            y_valid <= 1'b0;
            rr_ptr  <= '0;
        end else if (capture) begin
            y       <= cap_data;
            y_sel   <= cap_idx;
            y_valid <= 1'b1;
            if (mode == MODE_RR) rr_ptr <= SELW'(wrap_inc(int'(cap_idx), N));
        end else if (load) begin
            y_valid <= 1'b0;
        end
    end

`ifdef MUX_SEL_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            sel_err <= 1'b0;
        else if (load && mode == MODE_MANUAL && !sel_ok)
            sel_err <= 1'b1;
    end
`endif

endmodule
